// File: rtl/perm_engine.sv
// perm_engine: two-stage bit-permutation pipeline driven by a programmable table.
//
// tbl[i] holds the source bit index for output bit i.
//   forward (in_mode = 0): out[i]      = in[tbl[i]]
//   inverse (in_mode = 1): out[tbl[i]] = in[i], ascending i (last writer wins),
//                          output bits never written are 0
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_data + in_mode travel together
//   out_valid/out_ready  output handshake; out_data held while stalled
//   cfg_we/addr/data     table write port (only honoured when fully idle)
//   cfg_err              one-cycle pulse for a rejected table write
//   busy                 a word is held in either pipeline stage
//   word_cnt             wrapping count of results taken downstream
module perm_engine #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             cfg_we,
    input  logic [IDXW-1:0]  cfg_addr,
    input  logic [IDXW-1:0]  cfg_data,
    output logic             cfg_err,
    output logic             busy,
    output logic [15:0]      word_cnt
);

    // Range limit widened by one bit so WIDTH itself is representable.
    localparam logic [IDXW:0] LIMIT = (IDXW+1)'(WIDTH);

    logic [IDXW-1:0]  tbl [WIDTH];
    logic             rdy_en;
    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic             mode_p1;
    logic [WIDTH-1:0] perm_p1;
    logic             s2_free;
    logic             accept;
    logic             handshake;
    logic             cfg_ok;

    // rdy_en keeps in_ready low during reset and for the cycle it is released.
    assign s2_free   = !out_valid || out_ready;
    assign in_ready  = rdy_en && (!vld_p1 || s2_free);
    assign accept    = in_valid && in_ready;
    assign busy      = vld_p1 || out_valid;
    assign handshake = out_valid && out_ready;

    // Writes only land while the pipeline is empty and no word is being
    // offered, so the table seen by S2 never changes under a word in flight.
    assign cfg_ok = cfg_we && !busy && !in_valid
                    && ({1'b0, cfg_addr} < LIMIT)
                    && ({1'b0, cfg_data} < LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en    <= 1'b0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;
            word_cnt  <= 16'd0;
        end else begin
            rdy_en  <= 1'b1;
            cfg_err <= cfg_we && !cfg_ok;
            if (in_ready) begin
                vld_p1 <= in_valid;
            end
            if (s2_free) begin
                out_valid <= vld_p1;
            end
            if (handshake) begin
                word_cnt <= word_cnt + 16'd1;
            end
        end
    end

    // ---- S1: capture word and mode ----
    always_ff @(posedge clk) begin
        if (accept) begin
            data_p1 <= in_data;
            mode_p1 <= in_mode;
        end
    end

    always_comb begin
        perm_p1 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mode_p1) begin
                perm_p1[tbl[i]] = data_p1[i];
            end else begin
                perm_p1[i] = data_p1[tbl[i]];
            end
        end
    end

    // ---- S2: permuted result onto out_data ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (s2_free && vld_p1) begin
            out_data <= perm_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                tbl[i] <= IDXW'(i);
            end
        end else if (cfg_ok) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_perm_engine.sv
module tb_perm_engine;
    localparam int W  = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_mode = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_addr = '0;
    logic [IW-1:0] cfg_data = '0;
    logic          cfg_err;
    logic          busy;
    logic [15:0]   word_cnt;

    // 24-bit instance: the only way to present an index equal to WIDTH.
    logic          d2_in_valid = 1'b0;
    logic          d2_in_ready;
    logic [23:0]   d2_in_data = '0;
    logic          d2_in_mode = 1'b0;
    logic          d2_out_valid;
    logic          d2_out_ready = 1'b1;
    logic [23:0]   d2_out_data;
    logic          d2_cfg_we = 1'b0;
    logic [IW-1:0] d2_cfg_addr = '0;
    logic [IW-1:0] d2_cfg_data = '0;
    logic          d2_cfg_err;
    logic          d2_busy;
    logic [15:0]   d2_word_cnt;

    perm_engine #(.WIDTH(W), .IDXW(IW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .busy(busy), .word_cnt(word_cnt)
    );

    perm_engine #(.WIDTH(24), .IDXW(IW)) dut24 (
        .clk(clk), .rst(rst),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_data(d2_in_data), .in_mode(d2_in_mode),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_data(d2_out_data),
        .cfg_we(d2_cfg_we), .cfg_addr(d2_cfg_addr), .cfg_data(d2_cfg_data), .cfg_err(d2_cfg_err),
        .busy(d2_busy), .word_cnt(d2_word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           tsel;
        logic [W-1:0] d;
        logic         m;
        logic [W-1:0] e;
    } vec_t;

    localparam int NV = 15;
    vec_t         vecs [NV];
    int           checks = 0;
    int           errors = 0;
    int           mdl_tbl [W];
    int           new_tbl [W];
    int           hs_cnt = 0;
    logic [W-1:0] sb_q [$];

    // Independent count of downstream handshakes, sampled mid-low-phase.
    always begin
        @(negedge clk);
        #2;
        if (rst) hs_cnt = 0;
        else if (out_valid && out_ready) hs_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Forward: gather bit tbl[j] into position j by shifting.
    // Inverse: output bit j comes from the highest i whose entry names j.
    function automatic logic [W-1:0] ref_perm(input logic [W-1:0] d, input logic m);
        logic [W-1:0] r;
        int src;
        r = '0;
        for (int j = 0; j < W; j++) begin
            if (!m) begin
                r |= ((d >> mdl_tbl[j]) & 32'd1) << j;
            end else begin
                src = -1;
                for (int i = W - 1; i >= 0; i--) begin
                    if (mdl_tbl[i] == j) begin
                        src = i;
                        break;
                    end
                end
                if (src >= 0) r[j] = d[src];
            end
        end
        return r;
    endfunction

    task automatic fill(input int t);
        for (int i = 0; i < W; i++) begin
            case (t)
                0:       new_tbl[i] = i;
                1:       new_tbl[i] = (23 * i + 7) % 32;
                default: new_tbl[i] = (i == 3) ? 9 : i;
            endcase
        end
    endtask

    task automatic cfg_wr(input int a, input int d, output logic err);
        cfg_we   = 1'b1;
        cfg_addr = IW'(a);
        cfg_data = IW'(d);
        @(negedge clk);
        cfg_we = 1'b0;
        err    = cfg_err;
    endtask

    task automatic load_tbl();
        int   bad;
        logic e;
        bad = 0;
        for (int i = 0; i < W; i++) begin
            cfg_wr(i, new_tbl[i], e);
            if (e) bad++;
        end
        for (int i = 0; i < W; i++) mdl_tbl[i] = new_tbl[i];
        chk("tbl_load_err", 64'(bad), 64'd0);
    endtask

    task automatic xfer(input logic [W-1:0] d, input logic m, output logic [W-1:0] r, output int lat);
        int w;
        r = '0;
        lat = -1;
        w = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        out_ready = 1'b1;
        #1;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c < 20; c++) begin
            if (out_valid) begin
                lat = c;
                r = out_data;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] r;
        logic [W-1:0] w3 [3];
        logic         e;
        int           lat, acc, got, first, last, n, sent, cyc, seen, cur;

        vecs[0]  = '{0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
        vecs[1]  = '{0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{0, 32'h12345678, 1'b0, 32'h12345678};
        vecs[3]  = '{1, 32'h00010000, 1'b0, 32'h80000000};
        vecs[4]  = '{1, 32'h80000000, 1'b1, 32'h00010000};
        vecs[5]  = '{1, 32'h00000080, 1'b0, 32'h00000001};
        vecs[6]  = '{1, 32'h00000001, 1'b1, 32'h00000080};
        vecs[7]  = '{1, 32'h02000000, 1'b0, 32'h40000000};
        vecs[8]  = '{1, 32'h00000001, 1'b0, 32'h00008000};
        vecs[9]  = '{2, 32'h00000008, 1'b1, 32'h00000000};
        vecs[10] = '{2, 32'h00000200, 1'b1, 32'h00000200};
        vecs[11] = '{2, 32'h00000200, 1'b0, 32'h00000208};
        vecs[12] = '{2, 32'h00000008, 1'b0, 32'h00000000};
        vecs[13] = '{2, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFF7};
        vecs[14] = '{2, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF};

        // Reset state
        fill(0);
        for (int i = 0; i < W; i++) mdl_tbl[i] = i;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_before_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("in_ready_after_edge", 64'(in_ready), 64'd1);

        // Identity path
        xfer(32'hDEADBEEF, 1'b0, r, lat);
        chk("id_data", 64'(r), 64'hDEADBEEF);
        chk("id_latency", 64'(lat), 64'd2);
        chk("id_word_cnt", 64'(word_cnt), 64'd1);

        // Table-driven vectors
        cur = -1;
        for (int k = 0; k < NV; k++) begin
            if (vecs[k].tsel != cur) begin
                fill(vecs[k].tsel);
                load_tbl();
                cur = vecs[k].tsel;
            end
            xfer(vecs[k].d, vecs[k].m, r, lat);
            chk($sformatf("vec%0d_data", k), 64'(r), 64'(vecs[k].e));
            chk($sformatf("vec%0d_latency", k), 64'(lat), 64'd2);
        end

        // Backpressure: three words offered against a stalled output
        w3[0] = 32'h11112222;
        w3[1] = 32'hA5A50F0F;
        w3[2] = 32'h80000001;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_data   = w3[0];
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (in_ready) acc++;
            @(negedge clk);
            if (acc < 3) in_data = w3[acc];
        end
        #1;
        chk("bp_accepted", 64'(acc), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_data", 64'(out_data), 64'(ref_perm(w3[0], 1'b0)));
        repeat (2) @(negedge clk);
        chk("bp_stable_valid", 64'(out_valid), 64'd1);
        chk("bp_stable_data", 64'(out_data), 64'(ref_perm(w3[0], 1'b0)));
        out_ready = 1'b1;
        got = 0;
        first = -1;
        last = -1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (out_valid && got < 3) begin
                chk($sformatf("bp_order%0d", got), 64'(out_data), 64'(ref_perm(w3[got], 1'b0)));
                if (got == 0) first = k;
                last = k;
                got++;
            end
            if (in_valid && in_ready) acc++;
            @(negedge clk);
            if (acc >= 3) in_valid = 1'b0;
            else in_data = w3[acc];
        end
        chk("bp_delivered", 64'(got), 64'd3);
        chk("bp_back_to_back", 64'(last - first), 64'd2);
        chk("bp_idle_busy", 64'(busy), 64'd0);

        // Table write while busy is rejected
        fill(0);
        load_tbl();
        in_valid = 1'b1;
        in_data  = 32'h00000001;
        in_mode  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("busy_flag", 64'(busy), 64'd1);
        cfg_wr(0, 31, e);
        chk("busy_wr_err", 64'(e), 64'd1);
        @(negedge clk);
        chk("busy_err_one_cycle", 64'(cfg_err), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        xfer(32'h00000001, 1'b0, r, lat);
        chk("busy_wr_tbl_unchanged", 64'(r), 64'h1);

        // cfg_we alongside in_valid: write rejected, word accepted
        cfg_we   = 1'b1;
        cfg_addr = '0;
        cfg_data = 5'd31;
        in_valid = 1'b1;
        in_data  = 32'h00000001;
        @(negedge clk);
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        chk("prio_err", 64'(cfg_err), 64'd1);
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("prio_word_valid", 64'(out_valid), 64'd1);
        chk("prio_word_data", 64'(out_data), 64'h1);
        @(negedge clk);
        cfg_wr(31, 31, e);
        chk("idle_wr_ok", 64'(e), 64'd0);

        // Index range on a 24-bit instance
        d2_cfg_we = 1'b1; d2_cfg_addr = 5'd24; d2_cfg_data = 5'd0;
        @(negedge clk);
        d2_cfg_we = 1'b0;
        chk("w24_addr_eq_width", 64'(d2_cfg_err), 64'd1);
        d2_cfg_we = 1'b1; d2_cfg_addr = 5'd3; d2_cfg_data = 5'd24;
        @(negedge clk);
        d2_cfg_we = 1'b0;
        chk("w24_data_eq_width", 64'(d2_cfg_err), 64'd1);
        d2_cfg_we = 1'b1; d2_cfg_addr = 5'd23; d2_cfg_data = 5'd23;
        @(negedge clk);
        d2_cfg_we = 1'b0;
        chk("w24_in_range", 64'(d2_cfg_err), 64'd0);

        // Random tables, words, modes and stalls against the scoreboard
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < W; i++) new_tbl[i] = int'($urandom_range(31, 0));
            load_tbl();
            sb_q.delete();
            for (int k = 0; k < 200; k++) begin
                in_valid  = ($urandom_range(9, 0) < 7);
                in_data   = $urandom;
                in_mode   = 1'($urandom_range(1, 0));
                out_ready = ($urandom_range(9, 0) < 7);
                #1;
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) chk("rand_extra_out", 64'd1, 64'd0);
                    else chk("rand_out", 64'(out_data), 64'(sb_q.pop_front()));
                end
                if (in_valid && in_ready) sb_q.push_back(ref_perm(in_data, in_mode));
                @(negedge clk);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            cyc = 0;
            while (sb_q.size() > 0 && cyc < 20) begin
                #1;
                if (out_valid) chk("rand_out", 64'(out_data), 64'(sb_q.pop_front()));
                @(negedge clk);
                cyc++;
            end
            chk("rand_drain", 64'(sb_q.size()), 64'd0);
        end
        chk("word_cnt_vs_handshakes", 64'(word_cnt), 64'(16'(hs_cnt)));

        // Reset with two words in flight
        fill(1);
        load_tbl();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_data   = 32'h000000F0;
        @(negedge clk);
        in_data = 32'h00000F00;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_two_in_flight", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_word_cnt", 64'(word_cnt), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_in_ready", 64'(in_ready), 64'd0);
        chk("mid_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W; i++) mdl_tbl[i] = i;
        out_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mid_no_stale", 64'(seen), 64'd0);
        xfer(32'h00000001, 1'b0, r, lat);
        chk("mid_tbl_identity_a", 64'(r), 64'h1);
        xfer(32'h00010000, 1'b0, r, lat);
        chk("mid_tbl_identity_b", 64'(r), 64'h00010000);

        // Counter wrap
        n = 65535 - hs_cnt;
        sent = 0;
        cyc = 0;
        in_valid  = 1'b1;
        in_data   = 32'h0000CAFE;
        out_ready = 1'b1;
        while (sent < n && cyc < 70000) begin
            #1;
            if (in_ready) sent++;
            @(negedge clk);
            if (sent >= n) in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("wrap_pre", 64'(word_cnt), 64'hFFFF);
        xfer(32'h00000005, 1'b0, r, lat);
        chk("wrap_cnt", 64'(word_cnt), 64'h0);
        chk("wrap_data", 64'(r), 64'h5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
